// File: rtl/stream_fifo_pkg.sv
// Shared sizing helpers for stream_fifo and any parent that sinks its count.
package stream_fifo_pkg;

  function automatic int fifo_count_w(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port storage: one write port, registered read address.
module stream_fifo_ram #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [$clog2(DEPTH+1)-1:0]    wr_addr,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic [$clog2(DEPTH+1)-1:0]    rd_addr,
  output logic [WIDTH-1:0]              rd_data
);

  localparam int AW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_addr_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_addr_q <= rd_addr;
  end

  assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO: (DEPTH-1)-entry RAM ahead of a registered head word.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            write_en,
  input  logic [WIDTH-1:0]                data,
  input  logic                            read_ready,
  input  logic                            overflow_clear,
  output logic [WIDTH-1:0]                data_s,
  output logic                            valid_s,
  output logic [fifo_count_w(DEPTH)-1:0]  count,
  output logic                            full,
  output logic                            almost_full,
  output logic                            overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = fifo_count_w(DEPTH);
  localparam int RD = DEPTH - 1;

  logic [PW-1:0]    wptr, rptr, rptr_next, rd_addr;
  logic [WIDTH-1:0] ram_q;
  logic             pop, push, out_free, ram_nonempty;
  logic             load_ram, bypass, ram_wr;
  logic [CW-1:0]    count_next;

  // RAM depth is not a power of two, so wrap explicitly at RD-1
  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(RD - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop          = valid_s & read_ready;
    push         = write_en & (~full | pop);
    out_free     = ~valid_s | pop;
    ram_nonempty = count != {{(CW-1){1'b0}}, valid_s};
    load_ram     = out_free & ram_nonempty;
    bypass       = out_free & ~ram_nonempty & push;
    ram_wr       = push & ~bypass;
    rptr_next    = load_ram ? ptr_inc(rptr) : rptr;
    rd_addr      = reset_n ? rptr_next : '0;
    count_next   = count + CW'(push) - CW'(pop);
  end

  stream_fifo_ram #(.WIDTH(WIDTH), .DEPTH(RD)) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr & reset_n),
    .wr_addr (wptr),
    .wr_data (data),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      valid_s     <= 1'b0;
      data_s      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      rptr <= rptr_next;
      if (ram_wr) wptr <= ptr_inc(wptr);

      if (load_ram) begin
        data_s  <= ram_q;
        valid_s <= 1'b1;
      end else if (bypass) begin
        data_s  <= data;
        valid_s <= 1'b1;
      end else if (pop) begin
        valid_s <= 1'b0;
      end

      count       <= count_next;
      full        <= count_next == CW'(DEPTH);
      almost_full <= count_next >= CW'(AFULL_LEVEL);

      // a drop in the same cycle as a clear leaves the flag set
      if (write_en && !push)   overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed checks on a 4-deep FIFO plus a random soak of an 8-deep FIFO vs a queue model.
module tb_stream_fifo;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // 4-deep, 8-bit instance for directed tests
  logic       w4, rr4, oc4;
  logic [7:0] d4, ds4;
  logic       v4, f4, af4, of4;
  logic [2:0] c4;

  // 8-deep, 8-bit instance for the soak
  logic       w8, rr8, oc8;
  logic [7:0] d8, ds8;
  logic       v8, f8, af8, of8;
  logic [3:0] c8;

  stream_fifo #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .write_en(w4), .data(d4), .read_ready(rr4),
    .overflow_clear(oc4), .data_s(ds4), .valid_s(v4), .count(c4), .full(f4),
    .almost_full(af4), .overflow(of4));

  stream_fifo #(.WIDTH(8), .DEPTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .write_en(w8), .data(d8), .read_ready(rr8),
    .overflow_clear(oc8), .data_s(ds8), .valid_s(v8), .count(c8), .full(f8),
    .almost_full(af8), .overflow(of8));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [7:0] v);
    w4 = 1'b1; d4 = v; step(); w4 = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic       m_of, m_pop, m_push;
  int         nxt;

  initial begin
    reset_n = 1'b0;
    {w4, rr4, oc4, d4} = '0;
    {w8, rr8, oc8, d8} = '0;
    step(); step();
    chk("rst_valid", v4, 0);
    chk("rst_count", c4, 0);
    chk("rst_full", f4, 0);
    chk("rst_afull", af4, 0);
    chk("rst_ovf", of4, 0);
    chk("rst_data", ds4, 0);
    reset_n = 1'b1;
    step();

    // fill with read_ready low
    for (int i = 1; i <= 4; i++) begin
      push4(8'(i * 8'h11));
      chk("fill_count", c4, i);
      chk("fill_afull", af4, i >= 3);
      chk("fill_full", f4, i == 4);
      chk("fill_head", ds4, 8'h11);
      chk("fill_valid", v4, 1);
    end

    // drain, one word per cycle
    rr4 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", ds4, 8'(i * 8'h11));
      chk("drain_valid", v4, 1);
      step();
    end
    rr4 = 1'b0;
    chk("drain_empty_valid", v4, 0);
    chk("drain_empty_count", c4, 0);

    // refill, then drop a write while full
    for (int i = 1; i <= 4; i++) push4(8'(i * 8'h11));
    push4(8'h55);
    chk("ovf_set", of4, 1);
    chk("ovf_count", c4, 4);
    chk("ovf_head", ds4, 8'h11);
    oc4 = 1'b1; step(); oc4 = 1'b0;
    chk("ovf_clear", of4, 0);

    // full pass-through: push and pop every cycle
    q.delete();
    for (int i = 1; i <= 4; i++) q.push_back(8'(i * 8'h11));
    w4 = 1'b1; rr4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d4 = 8'(8'h60 + i);
      exp_d = q.pop_front();
      chk("pass_data", ds4, exp_d);
      q.push_back(d4);
      step();
      chk("pass_count", c4, 4);
      chk("pass_full", f4, 1);
      chk("pass_ovf", of4, 0);
    end
    w4 = 1'b0;
    while (q.size() > 0) begin
      exp_d = q.pop_front();
      chk("pass_drain", ds4, exp_d);
      step();
    end
    rr4 = 1'b0;
    chk("pass_empty", v4, 0);

    // bypass latency
    push4(8'hA5);
    chk("byp_valid", v4, 1);
    chk("byp_data", ds4, 8'hA5);
    chk("byp_count", c4, 1);
    rr4 = 1'b1; step(); rr4 = 1'b0;
    chk("byp_pop_valid", v4, 0);
    chk("byp_pop_count", c4, 0);

    // reset with three words held and a concurrent write
    push4(8'h01); push4(8'h02); push4(8'h03);
    chk("pre_rst_count", c4, 3);
    reset_n = 1'b0; w4 = 1'b1; d4 = 8'h77;
    step();
    w4 = 1'b0; reset_n = 1'b1;
    chk("mrst_valid", v4, 0);
    chk("mrst_data", ds4, 0);
    chk("mrst_count", c4, 0);
    chk("mrst_full", f4, 0);
    chk("mrst_afull", af4, 0);
    chk("mrst_ovf", of4, 0);
    push4(8'h88);
    chk("post_rst_data", ds4, 8'h88);
    chk("post_rst_count", c4, 1);

    // random soak of the 8-deep instance
    q.delete();
    m_of = 1'b0;
    nxt  = 0;
    for (int i = 0; i < 10000; i++) begin
      w8  = ($urandom_range(99) < 55);
      rr8 = ($urandom_range(99) < 50);
      oc8 = ($urandom_range(99) < 4);
      d8  = 8'($urandom);
      m_pop  = rr8 && (q.size() > 0);
      m_push = w8 && ((q.size() < 8) || m_pop);
      step();
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(d8);
      if (w8 && !m_push) m_of = 1'b1;
      else if (oc8)      m_of = 1'b0;
      chk("soak_count", c8, q.size());
      chk("soak_valid", v8, q.size() > 0);
      if (q.size() > 0) chk("soak_data", ds8, q[0]);
      chk("soak_full", f8, q.size() == 8);
      chk("soak_afull", af8, q.size() >= 7);
      chk("soak_ovf", of8, m_of);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
